bcd_serial_alu: RTL and testbench

- Parametrised, clocked BCD add/subtract unit that processes one decimal digit per clock, least-significant digit first.
- Generalises the board's 2-digit combinational BCD calculator to DIGITS digits behind a START/BUSY/DONE handshake.
- Subtraction returns a sign-magnitude result instead of flagging underflow.
- Sits between the switch/key input logic and the 7-segment display drivers. RESULT/NEG/OVF/BCD_ERR feed the HEX and LEDG decoders.

---
 rtl/bcd_serial_alu_pkg.sv | 23 ++
 rtl/bcd_serial_alu_digit_adder.sv | 26 ++
 rtl/bcd_serial_alu.sv | 174 +++++++++++++++++
 tb/tb_bcd_serial_alu.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_serial_alu_pkg.sv
// Shared types and constants for the digit-serial BCD add/subtract unit.
package bcd_serial_alu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_ADD,
    ST_FIX,
    ST_DONE
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_FIX6 = 4'd6;

  // 9's complement of a single decimal digit.
  function automatic logic [3:0] nines_comp(input logic [3:0] d);
    return BCD_MAX - d;
  endfunction

endpackage

// File: rtl/bcd_serial_alu_digit_adder.sv
// Single-digit BCD adder: a + b + cin with decimal correction.
module bcd_digit_adder
  import bcd_serial_alu_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] bin_sum;

  // Binary sum, then +6 whenever it leaves the decimal range (10..19).
  always_comb begin
    bin_sum = {1'b0, a} + {1'b0, b} + {4'd0, cin};
    if (bin_sum > {1'b0, BCD_MAX}) begin
      sum  = bin_sum[3:0] + BCD_FIX6;
      cout = 1'b1;
    end else begin
      sum  = bin_sum[3:0];
      cout = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_alu.sv
// Digit-serial BCD add/subtract with sign-magnitude subtraction result.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | waiting for START; operands latched on acceptance
// ST_CHECK | validate latched nibbles, seed carry (1 for subtract)
// ST_ADD   | one digit per cycle, LSD first: a + b' + carry
// ST_FIX   | A < B: recomplement the sum (0 - sum) to get B - A
// ST_DONE  | one-cycle DONE pulse, outputs already updated
module bcd_serial_alu
  import bcd_serial_alu_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET_N,
  input  logic                  START,
  input  logic                  OP,
  input  logic [4*DIGITS-1:0]   A,
  input  logic [4*DIGITS-1:0]   B,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [4*DIGITS-1:0]   RESULT,
  output logic                  NEG,
  output logic                  OVF,
  output logic                  BCD_ERR
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t          state;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic [W-1:0]    sum_reg;
  logic            op_reg;
  logic            carry;
  logic [IW-1:0]   idx;

  logic [3:0]      dig_a;
  logic [3:0]      dig_b;
  logic [3:0]      dig_sum;
  logic            dig_cout;
  logic [W-1:0]    sum_next;
  logic            bad_nibble;
  logic            last_digit;

  bcd_digit_adder u_digit_adder (
    .a    (dig_a),
    .b    (dig_b),
    .cin  (carry),
    .sum  (dig_sum),
    .cout (dig_cout)
  );

  // Adder operand select: FIX computes 0 + 9's complement of the stored sum.
  always_comb begin
    dig_a = a_reg[3:0];
    dig_b = b_reg[3:0];
    if (state == ST_FIX) begin
      dig_a = 4'd0;
      dig_b = nines_comp(sum_reg[3:0]);
    end else if (op_reg == OP_SUB) begin
      dig_b = nines_comp(b_reg[3:0]);
    end
  end

  // Sum digits enter at the top so the LSD ends up in [3:0] after DIGITS shifts.
  if (DIGITS == 1) begin : g_one
    assign sum_next = dig_sum;
  end else begin : g_many
    assign sum_next = {dig_sum, sum_reg[W-1:4]};
  end

  assign last_digit = (idx == IW'(DIGITS - 1));

  // Operand validity over the latched copies.
  always_comb begin
    bad_nibble = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a_reg[4*i +: 4] > BCD_MAX || b_reg[4*i +: 4] > BCD_MAX) bad_nibble = 1'b1;
    end
  end

  // Sequencer, datapath registers and registered outputs.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= ST_IDLE;
      a_reg   <= '0;
      b_reg   <= '0;
      sum_reg <= '0;
      op_reg  <= OP_ADD;
      carry   <= 1'b0;
      idx     <= '0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      RESULT  <= '0;
      NEG     <= 1'b0;
      OVF     <= 1'b0;
      BCD_ERR <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (START) begin
            a_reg  <= A;
            b_reg  <= B;
            op_reg <= OP;
            BUSY   <= 1'b1;
            state  <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          idx   <= '0;
          carry <= (op_reg == OP_SUB);
          if (bad_nibble) begin
            RESULT  <= '0;
            NEG     <= 1'b0;
            OVF     <= 1'b0;
            BCD_ERR <= 1'b1;
            BUSY    <= 1'b0;
            DONE    <= 1'b1;
            state   <= ST_DONE;
          end else begin
            state <= ST_ADD;
          end
        end
        ST_ADD: begin
          a_reg   <= a_reg >> 4;
          b_reg   <= b_reg >> 4;
          sum_reg <= sum_next;
          carry   <= dig_cout;
          if (last_digit) begin
            idx <= '0;
            if (op_reg == OP_SUB && !dig_cout) begin
              // No end-around carry: A < B, the sum is the 10's complement of B-A.
              carry <= 1'b1;
              state <= ST_FIX;
            end else begin
              RESULT  <= sum_next;
              NEG     <= 1'b0;
              OVF     <= (op_reg == OP_ADD) ? dig_cout : 1'b0;
              BCD_ERR <= 1'b0;
              BUSY    <= 1'b0;
              DONE    <= 1'b1;
              state   <= ST_DONE;
            end
          end else begin
            idx <= idx + IW'(1);
          end
        end
        ST_FIX: begin
          sum_reg <= sum_next;
          carry   <= dig_cout;
          if (last_digit) begin
            idx     <= '0;
            RESULT  <= sum_next;
            NEG     <= 1'b1;
            OVF     <= 1'b0;
            BCD_ERR <= 1'b0;
            BUSY    <= 1'b0;
            DONE    <= 1'b1;
            state   <= ST_DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_alu.sv
// Scoreboard bench for bcd_serial_alu at DIGITS=4.
module tb_bcd_serial_alu;

  localparam int D = 4;
  localparam int W = 4 * D;

  logic          CLOCK_50;
  logic          RESET_N;
  logic          START;
  logic          OP;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic          BUSY;
  logic          DONE;
  logic [W-1:0]  RESULT;
  logic          NEG;
  logic          OVF;
  logic          BCD_ERR;

  bcd_serial_alu #(.DIGITS(D)) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .START    (START),
    .OP       (OP),
    .A        (A),
    .B        (B),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .RESULT   (RESULT),
    .NEG      (NEG),
    .OVF      (OVF),
    .BCD_ERR  (BCD_ERR)
  );

  initial begin
    CLOCK_50 = 1'b0;
    forever #5 CLOCK_50 = ~CLOCK_50;
  end

  typedef struct {
    logic [W-1:0] res;
    logic         neg;
    logic         ovf;
    logic         err;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic int bcd_to_int(input logic [W-1:0] v);
    int r = 0;
    for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int_to_bcd(input int x);
    logic [W-1:0] r = '0;
    int t = x;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Reference model: decimal arithmetic on integers, pushed at drive time.
  task automatic push_expect(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
    exp_t e;
    int   ai, bi, lim;
    bit   bad = 0;
    lim = 1;
    for (int i = 0; i < D; i++) begin
      lim = lim * 10;
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) bad = 1;
    end
    e.res = '0; e.neg = 0; e.ovf = 0; e.err = 0; e.lat = 0;
    if (bad) begin
      e.err = 1;
      e.lat = 2;
    end else begin
      ai = bcd_to_int(a);
      bi = bcd_to_int(b);
      e.lat = D + 2;
      if (!op) begin
        e.res = int_to_bcd((ai + bi) % lim);
        e.ovf = (ai + bi) >= lim;
      end else if (ai >= bi) begin
        e.res = int_to_bcd(ai - bi);
      end else begin
        e.res = int_to_bcd(bi - ai);
        e.neg = 1;
        e.lat = 2 * D + 2;
      end
    end
    sb.push_back(e);
  endtask

  // Called at #1 after the accepting edge; waits for DONE and scores it.
  task automatic wait_result(input bit disturb, input logic [W-1:0] prev_res);
    exp_t e;
    int   n = 1;
    bit   seen = 0;
    bit   hold_ok = 1;
    while (n < 4 * D + 10) begin
      if (DONE) begin
        seen = 1;
        break;
      end
      if (!BUSY || RESULT !== prev_res) hold_ok = 0;
      if (disturb && n == 3) begin
        START = 1'b1;
        A     = 16'h9999;
      end
      @(posedge CLOCK_50);
      #1;
      n++;
      if (disturb && n == 4) START = 1'b0;
    end
    check("done_seen", seen, 1);
    if (sb.size() == 0) begin
      check("sb_nonempty", 0, 1);
    end else begin
      e = sb.pop_front();
      if (seen) begin
        check("result", RESULT, e.res);
        check("neg", NEG, e.neg);
        check("ovf", OVF, e.ovf);
        check("bcd_err", BCD_ERR, e.err);
        check("latency", n, e.lat);
        check("busy_at_done", BUSY, 0);
        check("busy_hold", hold_ok, 1);
      end
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic op, input bit disturb);
    logic [W-1:0] prev;
    push_expect(a, b, op);
    @(negedge CLOCK_50);
    START = 1'b1; OP = op; A = a; B = b;
    prev = RESULT;
    @(posedge CLOCK_50);
    #1;
    START = 1'b0;
    A = ~a;
    B = ~b;
    OP = ~op;
    wait_result(disturb, prev);
    @(posedge CLOCK_50);
    #1;
    check("done_pulse", DONE, 0);
  endtask

  initial begin
    logic [W-1:0] ra, rb, prev;
    RESET_N = 1'b0; START = 1'b0; OP = 1'b0; A = '0; B = '0;
    #1;
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_result", RESULT, 0);
    check("rst_flags", {NEG, OVF, BCD_ERR}, 0);
    repeat (2) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    RESET_N = 1'b1;

    run_op(16'h1234, 16'h5678, 1'b0, 0);
    run_op(16'h9999, 16'h0001, 1'b0, 0);
    run_op(16'h0500, 16'h0123, 1'b1, 0);
    run_op(16'h0123, 16'h0123, 1'b1, 0);
    run_op(16'h0123, 16'h0500, 1'b1, 0);
    run_op(16'h0000, 16'h9999, 1'b1, 0);
    run_op(16'h12A4, 16'h0000, 1'b0, 0);
    run_op(16'h0001, 16'h0001, 1'b0, 0);
    run_op(16'h0321, 16'h0456, 1'b0, 1);
    run_op(16'h0100, 16'h0321, 1'b1, 1);

    // Reset in the middle of ADD aborts with everything cleared.
    @(negedge CLOCK_50);
    START = 1'b1; OP = 1'b0; A = 16'h0777; B = 16'h0111;
    @(posedge CLOCK_50);
    #1;
    START = 1'b0;
    repeat (2) @(posedge CLOCK_50);
    #1;
    RESET_N = 1'b0;
    #1;
    check("abort_busy", BUSY, 0);
    check("abort_result", RESULT, 0);
    check("abort_flags", {DONE, NEG, OVF, BCD_ERR}, 0);
    repeat (2) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    RESET_N = 1'b1;
    for (int i = 0; i < 2 * D + 4; i++) begin
      @(posedge CLOCK_50);
      #1;
      check("abort_no_done", {DONE, BUSY}, 0);
    end
    run_op(16'h0042, 16'h0017, 1'b1, 0);

    // START held high: re-accepted in IDLE right after the DONE pulse.
    push_expect(16'h0001, 16'h0002, 1'b0);
    push_expect(16'h0003, 16'h0004, 1'b0);
    @(negedge CLOCK_50);
    START = 1'b1; OP = 1'b0; A = 16'h0001; B = 16'h0002;
    prev = RESULT;
    @(posedge CLOCK_50);
    #1;
    A = 16'h0003; B = 16'h0004;
    wait_result(0, prev);
    prev = RESULT;
    @(posedge CLOCK_50);
    #1;
    check("b2b_idle_busy", {DONE, BUSY}, 0);
    @(posedge CLOCK_50);
    #1;
    check("b2b_accept_busy", BUSY, 1);
    START = 1'b0;
    wait_result(0, prev);
    @(posedge CLOCK_50);
    #1;

    // Random mix, occasionally with an illegal nibble.
    for (int k = 0; k < 24; k++) begin
      for (int i = 0; i < D; i++) begin
        ra[4*i +: 4] = 4'($urandom_range(0, 9));
        rb[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 7) == 0) ra[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
      run_op(ra, rb, 1'($urandom_range(0, 1)), 0);
    end

    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
